// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared constants and fetch-entry type for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int              XLEN               = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int              IMEM_WORDS_DEFAULT = 256;
    localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : in-order FIFO of fetch entries, flush has priority over push
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  fetch_entry_t            entry_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output fetch_entry_t            head_o,
    output logic [$clog2(QDEPTH):0] count_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [QDEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [CW-1:0]  count_q;

    logic           w_do_pop;
    logic           w_do_push;
    logic [CW-1:0]  w_count_d;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop_i && (count_q != '0);
    assign w_do_push = push_i && ((count_q < CW'(QDEPTH)) || w_do_pop);

    always_comb begin
        w_count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            w_count_d = count_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= w_count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC generation, imem addressing, fault tracking and fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int          CW         = $clog2(QDEPTH) + 1;
    localparam logic [31:0] C_PC_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic          fault_q;
    logic          fault_d;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_pop;
    logic          w_pc_legal;
    logic          w_fetch;

    assign w_pop      = out_valid && out_ready;
    assign w_pc_legal = (pc_q[1:0] == 2'b00) && (pc_q < C_PC_LIMIT);
    assign w_fetch    = !fault_q && !redirect_valid && w_pc_legal
                        && ((w_count < CW'(QDEPTH)) || w_pop);

    assign w_push_entry.pc    = pc_q;
    assign w_push_entry.instr = imem_instr;

    // Redirect wins over everything; an illegal PC freezes in place until redirected.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
        end else if (!w_pc_legal) begin
            fault_d = 1'b1;
        end else if (w_fetch) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_fetch),
        .entry_i (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .head_o  (w_head),
        .count_o (w_count)
    );

    assign imem_addr   = pc_q;
    assign out_valid   = (w_count != '0);
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign fetch_fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : scoreboard bench for instr_fetch against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int          QD  = 2;
    localparam int          IMW = 256;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    instr_fetch #(
        .RESET_PC   (RPC),
        .IMEM_WORDS (IMW),
        .QDEPTH     (QD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_instr = mem_word(imem_addr);

    always #5 clk = ~clk;

    // Reference model: architectural PC, fault flag and the entries decode should see.
    fetch_entry_t exp_q[$];
    logic [31:0]  m_pc;
    logic         m_fault;
    bit           mon_en;
    int           n_cmp;
    int           n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            check("imem_addr", imem_addr, m_pc);
            check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
            if (exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", out_instr, exp_q[0].instr);
            end
        end
    end

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit legal;
        bit fetch;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        pop   = (exp_q.size() != 0) && rdy;
        legal = (m_pc[1:0] == 2'b00) && (m_pc < 32'(IMW * 4));
        fetch = !m_fault && !redir && legal && ((exp_q.size() < QD) || pop);
        if (pop) void'(exp_q.pop_front());
        if (redir) begin
            exp_q.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
        end else if (!legal) begin
            m_fault = 1'b1;
        end else if (fetch) begin
            exp_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        exp_q.delete();
        m_pc    = RPC;
        m_fault = 1'b0;
        rst     = 1'b0;
        mon_en  = 1'b1;
    endtask

    task automatic reset_mid();
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_imem_addr", imem_addr, RPC);
        @(negedge clk);
        release_reset();
    endtask

    initial begin
        logic [31:0] tgt;
        clk            = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        mon_en         = 1'b0;
        n_cmp          = 0;
        n_bad          = 0;
        m_pc           = RPC;
        m_fault        = 1'b0;

        #1;
        check("init_out_valid", {31'b0, out_valid}, 32'd0);
        check("init_out_pc", out_pc, 32'd0);
        check("init_fault", {31'b0, fetch_fault}, 32'd0);
        repeat (2) @(negedge clk);
        release_reset();

        // sequential stream
        repeat (8) cycle(1'b0, '0, 1'b1);

        // backpressure then drain
        reset_mid();
        repeat (5) cycle(1'b0, '0, 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b1);

        // redirect with a full queue
        repeat (3) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // simultaneous pop and redirect
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h40, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // end-of-memory boundary, then recovery
        cycle(1'b1, 32'h3F0, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h0, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // misaligned redirect, repeated illegal redirect, recovery
        cycle(1'b1, 32'h22, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h22, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h8, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 5))
                    0:       tgt = 32'h3F8;
                    1:       tgt = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                    2:       tgt = 32'hFFFF_FFFC;
                    default: tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                endcase
                cycle(1'b1, tgt, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, '0, ($urandom_range(0, 3) != 0));
            end
        end

        // reset in the middle of a stream
        repeat (3) cycle(1'b0, '0, 1'b0);
        reset_mid();
        repeat (4) cycle(1'b0, '0, 1'b1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
